// File: rtl/spi_reg_slave_if.sv
// SPI pin and register-bank bundle for spi_reg_slave.
// master: host/bench side driving the SPI pins; slave: the register slave.
interface spi_reg_slave_if #(
    parameter int NUM_REGS = 16
);
    logic                    sclk;
    logic                    ssel;
    logic                    mosi;
    logic                    miso;
    logic [NUM_REGS*8-1:0]   regs;
    logic                    wr_stb;
    logic [6:0]              wr_addr;

    modport master (
        output sclk, ssel, mosi,
        input  miso, regs, wr_stb, wr_addr
    );

    modport slave (
        input  sclk, ssel, mosi,
        output miso, regs, wr_stb, wr_addr
    );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: frame = command byte {W, addr[6:0]} + data byte(s).
// SPI pins are asynchronous and synchronised into clk before edge detection.
// Optional macro SPI_BURST_EN: further bytes auto-increment the address
// (wrapping 127->0); without it, bytes after the first data byte are ignored.
module spi_reg_slave #(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_reg_slave_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [7:0] NREGS8 = 8'(NUM_REGS);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ssel_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   ssel_d;

    logic sclk_s, ssel_s, mosi_s;
    logic sclk_rise, sclk_fall, ssel_rise, ssel_fall;

    state_t      state, state_next;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_shift;
    logic        cmd_w;
    logic [6:0]  cmd_addr;
    logic        addr_ok;
    logic        active;
    logic        byte_done;
    logic        wr_en;
    logic [7:0]  rd_byte;
    logic [7:0]  bank [NUM_REGS];
    logic        wr_stb_q;
    logic [6:0]  wr_addr_q;

    // Input synchronisers plus one delayed copy of the last stage for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ssel_sync <= '1;
            sclk_d    <= 1'b0;
            ssel_d    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], bus.ssel};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ssel_d    <= ssel_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ssel_s    = ssel_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ssel_rise = ssel_s & ~ssel_d;
    assign ssel_fall = ~ssel_s & ssel_d;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and byte-completion / write-enable strobes.
    always_comb begin
        state_next = state;
        active     = !ssel_rise && !ssel_fall && (state == ST_CMD || state == ST_DATA);
        byte_done  = active && sclk_rise && (bit_cnt == 3'd7);
        rx_byte    = {rx_shift, mosi_s};
        addr_ok    = ({1'b0, cmd_addr} < NREGS8);
        wr_en      = byte_done && (state == ST_DATA) && cmd_w && addr_ok;
        if (ssel_rise) begin
            state_next = ST_IDLE;
        end else if (ssel_fall) begin
            state_next = ST_CMD;
        end else if (byte_done) begin
            if (state == ST_CMD) begin
                state_next = ST_DATA;
            end else begin
`ifdef SPI_BURST_EN
                state_next = ST_DATA;
`else
                state_next = ST_DONE;
`endif
            end
        end
    end

    // Read mux; out-of-range addresses read as zero because no entry matches.
    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == 7'(i)) begin
                rd_byte = bank[i];
            end
        end
    end

    // Shift registers, command capture, register bank writes and MISO shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            cmd_w     <= 1'b0;
            cmd_addr  <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                bank[i] <= '0;
            end
        end else begin
            wr_stb_q <= 1'b0;
            if (ssel_rise) begin
                tx_shift <= '0;
            end else if (ssel_fall) begin
                bit_cnt  <= '0;
                tx_shift <= '0;
            end else begin
                if (active && sclk_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (byte_done && state == ST_CMD) begin
                        cmd_w    <= rx_byte[7];
                        cmd_addr <= rx_byte[6:0];
                    end
                    if (byte_done && state == ST_DATA) begin
                        if (wr_en) begin
                            wr_stb_q  <= 1'b1;
                            wr_addr_q <= cmd_addr;
                        end
`ifdef SPI_BURST_EN
                        cmd_addr <= cmd_addr + 7'd1;
`endif
                    end
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (wr_en && cmd_addr == 7'(i)) begin
                            bank[i] <= rx_byte;
                        end
                    end
                end
                if (sclk_fall) begin
                    if (state == ST_DATA) begin
                        // First fall of each data byte loads; the next seven shift.
                        if (bit_cnt == 3'd0) begin
                            tx_shift <= cmd_w ? 8'h00 : rd_byte;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end else if (state == ST_DONE) begin
                        tx_shift <= '0;
                    end
                end
            end
        end
    end

    assign bus.miso    = tx_shift[7];
    assign bus.wr_stb  = wr_stb_q;
    assign bus.wr_addr = wr_addr_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign bus.regs[8*g +: 8] = bank[g];
    end
endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: directed SPI frames against a
// register-array model; honours SPI_BURST_EN if defined for the build.
module tb_spi_reg_slave;
    localparam int NR   = 16;
    localparam int HALF = 6;
`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_reg_slave_if #(.NUM_REGS(NR)) bus ();

    spi_reg_slave #(.NUM_REGS(NR), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] mregs [NR];
    logic [6:0] m_last_addr;
    bit         quiet = 1'b0;
    int         got_q [$];
    int         exp_q [$];
    logic [7:0] last_rx [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR*8-1:0] model_flat();
        logic [NR*8-1:0] f;
        for (int i = 0; i < NR; i++) f[8*i +: 8] = mregs[i];
        return f;
    endfunction

    // Strobe monitor and idle-time comparison against the model.
    always @(negedge clk) begin
        if (bus.wr_stb === 1'b1) got_q.push_back(int'(bus.wr_addr));
        if (quiet) begin
            tests++;
            if (bus.regs !== model_flat()) begin
                fails++;
                $display("FAIL idle_regs: got %h expected %h", bus.regs, model_flat());
            end
            check("idle_miso", 32'(bus.miso), 32'd0);
            check("idle_wr_stb", 32'(bus.wr_stb), 32'd0);
            check("idle_wr_addr", 32'(bus.wr_addr), 32'(m_last_addr));
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int b = 0; b < nbits; b++) begin
            bus.mosi = tx[7-b];
            wait_clks(HALF);
            rx[7-b]  = bus.miso;
            bus.sclk = 1'b1;
            wait_clks(HALF);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic frame(input string name, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int nbytes, input int tail_bits);
        logic [7:0] bytes [3];
        logic [7:0] exp_rx [3];
        logic [7:0] rx;
        logic       w;
        int         a;
        int         ak;
        quiet = 1'b0;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        w = b0[7];
        a = int'(b0[6:0]);
        exp_q.delete();
        for (int k = 0; k < 3; k++) exp_rx[k] = 8'h00;
        for (int k = 1; k < nbytes; k++) begin
            if (k == 1 || BURST) begin
                ak = (a + k - 1) % 128;
                if (w) begin
                    if (ak < NR) begin
                        mregs[ak]   = bytes[k];
                        m_last_addr = 7'(ak);
                        exp_q.push_back(ak);
                    end
                end else begin
                    exp_rx[k] = (ak < NR) ? mregs[ak] : 8'h00;
                end
            end
        end
        wait_clks(2);
        got_q.delete();
        bus.ssel = 1'b0;
        wait_clks(HALF);
        for (int k = 0; k < nbytes; k++) begin
            shift_bits(bytes[k], 8, rx);
            last_rx[k] = rx;
            check($sformatf("%s_miso_byte%0d", name, k), 32'(rx), 32'(exp_rx[k]));
        end
        if (tail_bits > 0) shift_bits(bytes[nbytes], tail_bits, rx);
        wait_clks(HALF);
        bus.ssel = 1'b1;
        wait_clks(12);
        check($sformatf("%s_stb_count", name), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_stb_addr%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        quiet = 1'b1;
    endtask

    initial begin
        bus.sclk = 1'b0;
        bus.ssel = 1'b1;
        bus.mosi = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
        m_last_addr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_regs_lo", bus.regs[31:0], 32'h0);
        check("rst_regs_hi", bus.regs[127:96], 32'h0);
        check("rst_miso", 32'(bus.miso), 32'd0);
        check("rst_wr_stb", 32'(bus.wr_stb), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        rst = 1'b0;
        wait_clks(4);
        quiet = 1'b1;
        wait_clks(4);

        // Write then read back
        frame("wr3", 8'h83, 8'hA5, 8'h00, 2, 0);
        check("wr3_reg_lit", 32'(bus.regs[31:24]), 32'hA5);
        check("wr3_addr_lit", 32'(bus.wr_addr), 32'd3);
        check("wr3_model_lit", 32'(mregs[3]), 32'hA5);
        frame("rd3", 8'h03, 8'h00, 8'h00, 2, 0);
        check("rd3_data_lit", 32'(last_rx[1]), 32'hA5);

        // Out of range
        frame("wr_oor", 8'h90, 8'h55, 8'h00, 2, 0);
        frame("rd_oor", 8'h10, 8'h00, 8'h00, 2, 0);
        check("rd_oor_lit", 32'(last_rx[1]), 32'h00);

        // Abort mid data byte, then full frame
        frame("abort", 8'h82, 8'h3C, 8'h00, 1, 4);
        check("abort_reg2_lit", 32'(bus.regs[23:16]), 32'h00);
        frame("wr2", 8'h82, 8'h3C, 8'h00, 2, 0);
        check("wr2_reg_lit", 32'(bus.regs[23:16]), 32'h3C);

        // SPI activity with ssel high is ignored (idle checks run throughout)
        begin
            logic [7:0] dummy;
            shift_bits(8'h85, 8, dummy);
            shift_bits(8'hFF, 8, dummy);
        end
        wait_clks(8);

        // Third byte: burst vs. ignored
        frame("wr15", 8'h8F, 8'h11, 8'h22, 3, 0);
        check("wr15_reg_lit", 32'(bus.regs[127:120]), 32'h11);
        check("wr15_stb_lit", 32'(got_q.size()), 32'd1);
        frame("wr4", 8'h84, 8'h5A, 8'h00, 2, 0);
        frame("rd_burst", 8'h03, 8'h00, 8'h00, 3, 0);
        check("rd_burst_b1_lit", 32'(last_rx[1]), 32'hA5);
        check("rd_burst_b2_lit", 32'(last_rx[2]), BURST ? 32'h5A : 32'h00);

        wait_clks(10);
        quiet = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
